// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register file and launch/writeback sequencer for an external mul/div unit.
// Ports: clk, rst (sync, active-high); op_valid/op/rs_data/rt_data/flush from the pipeline;
//        dmu_a/dmu_b/dmu_m/div_begin to the mul/div unit, dmu_stall/hi_in/lo_in back from it;
//        hi/lo architectural registers, mf_data MFHI/MFLO read data, stall_o pipeline hold,
//        wd_err watchdog abort flag.
// Optional watchdog on a stuck mul/div unit: define HILO_WATCHDOG_EN.
module hilo_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic [31:0] dmu_a,
  output logic [31:0] dmu_b,
  output logic [3:0]  dmu_m,
  output logic [1:0]  div_begin,
  input  logic        dmu_stall,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data,
  output logic        stall_o,
  output logic        wd_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [3:0] m_q, m_d, m_code;
  logic busy, launch, done, wd_to, is_div;
  assign busy   = state_q == BUSY;
  assign launch = !busy && op_valid && op >= 4'd1 && op <= 4'd4 && !flush;
  assign is_div = op == 4'd3 || op == 4'd4;
  // flush takes precedence over a result arriving in the same cycle
  assign done   = busy && !flush && !dmu_stall;
  always_comb
    m_code = op == 4'd1 ? 4'd5 : op == 4'd2 ? 4'd6 : op == 4'd3 ? 4'd11 : op == 4'd4 ? 4'd7 : 4'd0;
`ifdef HILO_WATCHDOG_EN
  logic [5:0] wd_cnt_q;
  logic       wd_err_q;
  // the count reaches 63 on the edge that ends the 63rd BUSY cycle
  assign wd_to  = busy && dmu_stall && !flush && wd_cnt_q == 6'd62;
  assign wd_err = wd_err_q;
  always_ff @(posedge clk)
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= launch ? 6'd0 : busy ? wd_cnt_q + 6'd1 : wd_cnt_q;
      if (wd_to) wd_err_q <= 1'b1;
    end
`else
  assign wd_to  = 1'b0;
  assign wd_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = launch ? BUSY : (busy && (flush || !dmu_stall || wd_to)) ? IDLE : state_q;
  always_comb begin
    dmu_a     = busy ? a_q : rs_data;
    dmu_b     = busy ? b_q : rt_data;
    dmu_m     = busy ? m_q : launch ? m_code : 4'd0;
    div_begin = launch ? (is_div ? 2'd1 : 2'd2) : 2'd0;
    stall_o   = busy || launch;
    mf_data   = (!busy && op_valid && op == 4'd7) ? hi_q :
                (!busy && op_valid && op == 4'd8) ? lo_q : 32'd0;
  end
  // MT writes are only honoured in IDLE and are not cancelled by flush
  always_comb begin
    hi_d = done ? hi_in : (!busy && op_valid && op == 4'd5) ? rs_data : hi_q;
    lo_d = done ? lo_in : (!busy && op_valid && op == 4'd6) ? rs_data : lo_q;
    a_d  = launch ? rs_data : a_q;
    b_d  = launch ? rt_data : b_q;
    m_d  = launch ? m_code : m_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      a_q  <= a_d;
      b_q  <= b_d;
      m_q  <= m_d;
    end
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
